// File: rtl/dec7_seg.sv
// dec7_seg: registered hex nibble to seven-segment decoder.
// leds bit6..bit0 = a..g; ACTIVE_LOW flips polarity for common anode.
module dec7_seg #(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] binary,
  input  logic       blank,
  input  logic       en,
  output logic [6:0] leds
);

  // Glyph ROM packed as 16 x 7 bits, digit 0 in the low slice.
  localparam logic [111:0] GLYPHS = {
    7'h47, 7'h4F, 7'h3D, 7'h4E,
    7'h1F, 7'h77, 7'h7B, 7'h7F,
    7'h70, 7'h5F, 7'h5B, 7'h33,
    7'h79, 7'h6D, 7'h30, 7'h7E
  };

  localparam logic [6:0] POL = {7{ACTIVE_LOW}};
  localparam logic [6:0] OFF = POL;

  logic [6:0] idx;
  logic [6:0] glyph;
  logic [6:0] pattern;

  // idx = binary*7; an X nibble yields an X select in simulation.
  assign idx = {binary, 3'b000} - {3'b000, binary};

  always_comb begin
    glyph   = GLYPHS[idx +: 7];
    pattern = (blank ? 7'h00 : glyph) ^ POL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      leds <= OFF;
    end else if (en) begin
      leds <= pattern;
    end
  end

endmodule

// File: tb/tb_dec7_seg.sv
// tb_dec7_seg: directed checks of both polarities of dec7_seg.
// Hand-computed glyph table; outputs sampled 1ns after rising edges.
module tb_dec7_seg;

  logic       clk;
  logic       rst_n;
  logic [3:0] binary;
  logic       blank;
  logic       en;
  logic [6:0] leds_hi;
  logic [6:0] leds_lo;

  int nvec;
  int nerr;

  logic [6:0] tbl [16];

  dec7_seg #(.ACTIVE_LOW(1'b0)) u_hi (
    .clk    (clk),
    .rst_n  (rst_n),
    .binary (binary),
    .blank  (blank),
    .en     (en),
    .leds   (leds_hi)
  );

  dec7_seg #(.ACTIVE_LOW(1'b1)) u_lo (
    .clk    (clk),
    .rst_n  (rst_n),
    .binary (binary),
    .blank  (blank),
    .en     (en),
    .leds   (leds_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string      tag,
    input logic [6:0] got,
    input logic [6:0] exp
  );
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk2(
    input string      tag,
    input logic [6:0] exp_hi
  );
    chk({tag, "_hi"}, leds_hi, exp_hi);
    chk({tag, "_lo"}, leds_lo, ~exp_hi);
  endtask

  initial begin
    logic [6:0] prev;
    nvec = 0;
    nerr = 0;
    tbl[0]  = 7'h7E; tbl[1]  = 7'h30;
    tbl[2]  = 7'h6D; tbl[3]  = 7'h79;
    tbl[4]  = 7'h33; tbl[5]  = 7'h5B;
    tbl[6]  = 7'h5F; tbl[7]  = 7'h70;
    tbl[8]  = 7'h7F; tbl[9]  = 7'h7B;
    tbl[10] = 7'h77; tbl[11] = 7'h1F;
    tbl[12] = 7'h4E; tbl[13] = 7'h3D;
    tbl[14] = 7'h4F; tbl[15] = 7'h47;

    rst_n  = 1'b1;
    en     = 1'b0;
    blank  = 1'b0;
    binary = 4'h0;

    #2 rst_n = 1'b0;
    #1;
    chk2("rst_async", 7'h00);

    en     = 1'b1;
    binary = 4'h8;
    tick();
    chk2("rst_held", 7'h00);

    rst_n  = 1'b1;
    binary = 4'h0;
    tick();
    chk2("rst_first", 7'h7E);

    prev = 7'h7E;
    for (int i = 0; i < 16; i++) begin
      binary = 4'(i);
      #2;
      chk2($sformatf("lat_%0d", i), prev);
      tick();
      $display("t=%0t binary=%h leds=%h/%h",
               $time, binary, leds_hi, leds_lo);
      chk2($sformatf("sweep_%0d", i), tbl[i]);
      prev = tbl[i];
    end

    binary = 4'h8;
    blank  = 1'b1;
    tick();
    chk2("blank_on", 7'h00);
    blank = 1'b0;
    tick();
    chk2("blank_off", 7'h7F);

    binary = 4'h5;
    tick();
    chk2("hold_load", 7'h5B);
    en     = 1'b0;
    binary = 4'h2;
    blank  = 1'b1;
    tick();
    chk2("hold_a", 7'h5B);
    blank = 1'b0;
    tick();
    chk2("hold_b", 7'h5B);
    en = 1'b1;
    tick();
    chk2("hold_rel", 7'h6D);

    #3 rst_n = 1'b0;
    #1;
    chk2("rst_mid", 7'h00);
    tick();
    chk2("rst_mid_held", 7'h00);
    rst_n  = 1'b1;
    binary = 4'hA;
    tick();
    chk2("rst_mid_rel", 7'h77);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
